// File: rtl/pc_clk_gen_if.sv
// rtl/pc_clk_gen_if.sv - enable/output bundle between pc_clk_gen and its consumer
//
// Purpose: carries the count enable into the divider and the divided clock,
//          phase count and edge pulses back out.
// Signals:
//   en        - count enable (master -> slave)
//   clk_out   - divided PC clock (slave -> master)
//   phase     - position in the divide cycle, 0..DIV-1 (slave -> master)
//   rise_tick - one-cycle pulse on the first high cycle of clk_out
//   fall_tick - one-cycle pulse on the first low cycle of clk_out
// The slave modport is the divider side; the master modport is the user side.

interface pc_clk_gen_if #(
    parameter int DIV = 4
);
    localparam int PHASE_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic               en;
    logic               clk_out;
    logic [PHASE_W-1:0] phase;
    logic               rise_tick;
    logic               fall_tick;

    modport master (
        output en,
        input  clk_out,
        input  phase,
        input  rise_tick,
        input  fall_tick
    );

    modport slave (
        input  en,
        output clk_out,
        output phase,
        output rise_tick,
        output fall_tick
    );
endinterface

// File: rtl/pc_clk_gen.sv
// rtl/pc_clk_gen.sv - program-counter clock divider with phase count and edge pulses
//
// Purpose: divides clk_in by DIV to produce clk_out (low LO_CNT cycles, then
//          high HI_CNT cycles) and exports the phase plus registered
//          rise/fall pulses aligned with the clk_out level changes.
// Ports:
//   clk_in - system clock, all state changes on its rising edge
//   rst_n  - asynchronous active-low reset, release sampled on clk_in
//   bus    - pc_clk_gen_if.slave: en in; clk_out, phase, rise_tick, fall_tick out
// Every output comes straight from a flop.

module pc_clk_gen #(
    parameter int DIV = 4
) (
    input  logic          clk_in,
    input  logic          rst_n,
    pc_clk_gen_if.slave   bus
);
    localparam int PHASE_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int HI_CNT  = DIV / 2;
    localparam int LO_CNT  = DIV - HI_CNT;

    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(DIV - 1);
    localparam logic [PHASE_W-1:0] PH_HI   = PHASE_W'(LO_CNT);
    localparam logic [PHASE_W-1:0] PH_PRE  = PHASE_W'(LO_CNT - 1);

    if (DIV < 2) begin : g_bad_div
        $error("pc_clk_gen: DIV must be at least 2");
    end

    logic [PHASE_W-1:0] phase_q,     phase_d;
    logic               clk_out_q,   clk_out_d;
    logic               rise_tick_q, rise_tick_d;
    logic               fall_tick_q, fall_tick_d;

    always_comb begin
        phase_d     = phase_q;
        clk_out_d   = clk_out_q;
        rise_tick_d = 1'b0;
        fall_tick_d = 1'b0;
        if (bus.en) begin
            phase_d     = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            // Derived from the next phase so clk_out moves on the same edge as phase.
            clk_out_d   = (phase_d >= PH_HI);
            rise_tick_d = (phase_q == PH_PRE);
            fall_tick_d = (phase_q == PH_LAST);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            clk_out_q   <= 1'b0;
            rise_tick_q <= 1'b0;
            fall_tick_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            clk_out_q   <= clk_out_d;
            rise_tick_q <= rise_tick_d;
            fall_tick_q <= fall_tick_d;
        end
    end

    assign bus.phase     = phase_q;
    assign bus.clk_out   = clk_out_q;
    assign bus.rise_tick = rise_tick_q;
    assign bus.fall_tick = fall_tick_q;
endmodule

// File: tb/tb_pc_clk_gen.sv
// tb/tb_pc_clk_gen.sv - scoreboard bench for pc_clk_gen at DIV = 4, 3 and 2

module tb_pc_clk_gen;
    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    always #5 clk_in = ~clk_in;

    pc_clk_gen_if #(.DIV(4)) if4 ();
    pc_clk_gen_if #(.DIV(3)) if3 ();
    pc_clk_gen_if #(.DIV(2)) if2 ();

    pc_clk_gen #(.DIV(4)) dut4 (.clk_in(clk_in), .rst_n(rst_n), .bus(if4.slave));
    pc_clk_gen #(.DIV(3)) dut3 (.clk_in(clk_in), .rst_n(rst_n), .bus(if3.slave));
    pc_clk_gen #(.DIV(2)) dut2 (.clk_in(clk_in), .rst_n(rst_n), .bus(if2.slave));

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] ph;
        logic       clk;
        logic       rise;
        logic       fall;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   divs[3] = '{4, 3, 2};
    int   m_ph[3];
    logic m_clk[3];

    // Observed {phase, clk_out, rise_tick, fall_tick} of one DUT, phase zero-extended.
    function automatic logic [6:0] obs(input int id);
        case (id)
            0:       return {2'b00, if4.phase, if4.clk_out, if4.rise_tick, if4.fall_tick};
            1:       return {2'b00, if3.phase, if3.clk_out, if3.rise_tick, if3.fall_tick};
            default: return {3'b000, if2.phase, if2.clk_out, if2.rise_tick, if2.fall_tick};
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ph[i]  = 0;
            m_clk[i] = 1'b0;
        end
    endfunction

    // Drive one enabled/stalled cycle on every DUT; expectations are queued
    // before the edge and popped against the DUT right after it.
    task automatic cycle(input logic e4, input logic e3, input logic e2);
        logic e[3];
        e = '{e4, e3, e2};
        if4.en = e4;
        if3.en = e3;
        if2.en = e2;
        for (int i = 0; i < 3; i++) begin
            exp_t x;
            int   np;
            logic nclk;
            np   = e[i] ? (m_ph[i] + 1) % divs[i] : m_ph[i];
            nclk = (np >= divs[i] - divs[i] / 2);
            x.id   = 2'(i);
            x.ph   = 4'(np);
            x.clk  = nclk;
            x.rise = e[i] && !m_clk[i] && nclk;
            x.fall = e[i] && m_clk[i] && !nclk;
            m_ph[i]  = np;
            m_clk[i] = nclk;
            sb.push_back(x);
        end
        @(posedge clk_in);
        #1;
        while (sb.size() > 0) begin
            exp_t       x;
            logic [6:0] got;
            x   = sb.pop_front();
            got = obs(int'(x.id));
            checks++;
            if (got !== {x.ph, x.clk, x.rise, x.fall}) begin
                errors++;
                $display("FAIL sb_div%0d: got ph=%0d clk=%b rise=%b fall=%b, want ph=%0d clk=%b rise=%b fall=%b",
                         divs[x.id], got[6:3], got[2], got[1], got[0], x.ph, x.clk, x.rise, x.fall);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if4.en = 1'b1;
        if3.en = 1'b1;
        if2.en = 1'b1;
        repeat (3) begin
            @(posedge clk_in);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== 7'd0) begin
                    errors++;
                    $display("FAIL reset_hold_div%0d: got %b want 0000000", divs[i], obs(i));
                end
            end
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_free_run();
        logic [7:0] pat = '0;
        realtime    t_rise[$];
        for (int n = 0; n < 12; n++) begin
            cycle(1'b1, 1'b1, 1'b1);
            if (n < 8) pat = {pat[6:0], if4.clk_out};
            if (if4.rise_tick) t_rise.push_back($realtime);
        end
        checks++;
        if (pat !== 8'b01100110) begin
            errors++;
            $display("FAIL free_run_pattern: got %b want 01100110", pat);
        end
        checks++;
        if (t_rise.size() < 2 || (t_rise[1] - t_rise[0]) != 40.0) begin
            errors++;
            $display("FAIL free_run_period: got %0d rises, first gap %0t want 40",
                     t_rise.size(), (t_rise.size() >= 2) ? t_rise[1] - t_rise[0] : 0.0);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int rises = 0;
        int falls = 0;
        while (if4.phase != 2'd2 && n < 8) begin
            cycle(1'b1, 1'b1, 1'b1);
            n++;
        end
        checks++;
        if (if4.phase !== 2'd2 || if4.rise_tick !== 1'b1) begin
            errors++;
            $display("FAIL stall_arrive: got ph=%0d rise=%b want ph=2 rise=1", if4.phase, if4.rise_tick);
        end
        rises = 1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 1'b1);
            if (if4.rise_tick) rises++;
            checks++;
            if (if4.phase !== 2'd2 || if4.clk_out !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: got ph=%0d clk=%b want ph=2 clk=1", if4.phase, if4.clk_out);
            end
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL stall_rise_count: got %0d want 1", rises);
        end
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (if4.phase !== 2'd3) begin
            errors++;
            $display("FAIL stall_resume: got ph=%0d want 3", if4.phase);
        end
        if (if4.fall_tick) falls++;
        cycle(1'b1, 1'b1, 1'b1);
        if (if4.fall_tick) falls++;
        checks++;
        if (if4.phase !== 2'd0 || falls != 1) begin
            errors++;
            $display("FAIL stall_wrap: got ph=%0d falls=%0d want ph=0 falls=1", if4.phase, falls);
        end
    endtask

    task automatic test_odd_ratio();
        for (int n = 0; n < 6; n++) begin
            cycle(1'b1, 1'b1, 1'b1);
            checks++;
            if (if3.clk_out !== (if3.phase == 2'd2) ||
                (if3.rise_tick && if3.phase != 2'd2) ||
                (if3.fall_tick && if3.phase != 2'd0)) begin
                errors++;
                $display("FAIL odd_div3: got ph=%0d clk=%b rise=%b fall=%b want clk=(ph==2) rise@2 fall@0",
                         if3.phase, if3.clk_out, if3.rise_tick, if3.fall_tick);
            end
        end
    endtask

    task automatic test_min_ratio();
        logic prev;
        prev = if2.clk_out;
        for (int n = 0; n < 6; n++) begin
            cycle(1'b1, 1'b1, 1'b1);
            checks++;
            if (if2.clk_out === prev || (if2.rise_tick ^ if2.fall_tick) !== 1'b1 ||
                if2.rise_tick !== if2.clk_out) begin
                errors++;
                $display("FAIL min_div2: got clk=%b prev=%b rise=%b fall=%b want toggle and one tick",
                         if2.clk_out, prev, if2.rise_tick, if2.fall_tick);
            end
            prev = if2.clk_out;
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int edges = 0;
        while (if4.phase != 2'd3 && n < 8) begin
            cycle(1'b1, 1'b1, 1'b1);
            n++;
        end
        checks++;
        if (if4.phase !== 2'd3 || if4.clk_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: got ph=%0d clk=%b want ph=3 clk=1", if4.phase, if4.clk_out);
        end
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== 7'd0) begin
                errors++;
                $display("FAIL reset_async_div%0d: got %b want 0000000", divs[i], obs(i));
            end
        end
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        model_reset();
        while (edges < 10) begin
            cycle(1'b1, 1'b1, 1'b1);
            edges++;
            if (if4.rise_tick) break;
        end
        checks++;
        if (edges != 2) begin
            errors++;
            $display("FAIL reset_first_rise: got edge %0d want 2", edges);
        end
    endtask

    initial begin
        if4.en = 1'b0;
        if3.en = 1'b0;
        if2.en = 1'b0;
        model_reset();
        test_reset();
        test_free_run();
        test_stall();
        test_odd_ratio();
        test_min_ratio();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_clk_gen.md
# pc_clk_gen

Program-counter clock generator for the MIPS processor. Divides the free-running system clock `clk_in` by a fixed ratio and produces `clk_out`, the slow clock that advances the PC and the rest of the datapath. It also exports a phase count and single-cycle edge pulses so logic in the `clk_in` domain can sequence work against `clk_out`. It sits at the top of the processor, between the board/testbench clock source and the PC register.

## Interface

Parameters:
- `DIV`: default 4. Division ratio; `clk_out` period = `DIV` `clk_in` cycles. Legal range: `DIV` >= 2; values < 2 are a compile-time error.
- Derived localparams, not overridable:
  - `PHASE_W` = max(1, clog2(`DIV`)).
  - `HI_CNT` = floor(`DIV`/2).
  - `LO_CNT` = `DIV` - `HI_CNT`.

Ports (clock and reset first):
- `clk_in`: input, 1. System clock; all state changes on its rising edge.
- `rst_n`: input, 1. Reset: asynchronous, active-low. Asserting it immediately forces all state to reset values. Release is sampled on `clk_in`.
- `en`: input, 1. Count enable; 0 freezes the divider.
- `clk_out`: output, 1. Divided PC clock, driven directly from a flop (glitch-free).
- `phase`: output, `PHASE_W`. Current position in the divide cycle, 0..`DIV`-1.
- `rise_tick`: output, 1. One `clk_in`-cycle pulse coincident with the first high cycle of `clk_out`.
- `fall_tick`: output, 1. One `clk_in`-cycle pulse coincident with the first low cycle of `clk_out`.

## Operation

- Phase counter:
  - On each rising `clk_in` edge with `en`=1, `phase` increments.
  - `DIV`-1 wraps to 0.
  - With `en`=0, `phase` holds.
- `clk_out`:
  - Registered; it is always equal to (`phase` >= `LO_CNT`). The flop is computed from next-phase so it changes in the same edge as `phase`.
  - Low for `LO_CNT` cycles, then high for `HI_CNT` cycles.
  - Even `DIV`: 50% duty. Odd `DIV`: low phase is one cycle longer.
- `rise_tick`:
  - Registered.
  - Set to 1 on an edge where `en`=1 and `phase` advances from `LO_CNT`-1 to `LO_CNT`; otherwise 0.
- `fall_tick`:
  - Registered.
  - Set to 1 on an edge where `en`=1 and `phase` wraps `DIV`-1 to 0; otherwise 0.
- Stall (`en`=0): `phase` and `clk_out` hold. Both ticks are 0 on the next edge, so a tick never repeats during a stall.
- Resuming (`en`=1): counting continues from the held phase; no cycles are lost or inserted.
- Reset values, applied asynchronously on `rst_n`=0: `phase`=0, `clk_out`=0, `rise_tick`=0, `fall_tick`=0.
- Reset mid-operation: `clk_out` drops to 0 immediately, even mid-high phase. This is the only case in which `clk_out` has a high period shorter than `HI_CNT` cycles.
- No combinational path from any input to any output.

## Timing

- Latency: first `clk_out` rise occurs `LO_CNT` enabled edges after reset release.
  - `DIV`=4: rise at the 2nd enabled edge, fall at the 4th, period 4 cycles.
- All outputs change only on rising `clk_in` edges, except the asynchronous reset assertion.
- `rise_tick` and `fall_tick` are high in exactly the same `clk_in` cycle as the corresponding `clk_out` level change. They are never high simultaneously; for `DIV`=2 they alternate every cycle.
- `en` is sampled at the `clk_in` edge. A change of `en` affects the count at that edge only.
- With a 10-unit `clk_in` period and `DIV`=4, `clk_out` has a 40-unit period, high for 20 units.

## Test plan

- Reset: hold `rst_n`=0 while toggling `clk_in`. Required: `phase`=0, `clk_out`=0, both ticks 0. Then assert `rst_n`=0 asynchronously mid-high phase; `clk_out` must go 0 without waiting for a clock edge.
- Free run, `DIV`=4, `en`=1, `clk_in` period 10:
  - `phase` sequence 0,1,2,3,0,... after release.
  - `clk_out` pattern 0,0,1,1 repeating.
  - `rise_tick` high on phase 2, `fall_tick` high on phase 0 after wrap.
  - Measured `clk_out` period 40.
- Stall, `DIV`=4: drop `en` for 3 cycles at phase 2.
  - `phase` stays 2 and `clk_out` stays 1 throughout the stall.
  - `rise_tick` is 1 for only the first cycle.
  - After `en` returns, `phase` goes 3 then 0, and `fall_tick` pulses once.
- Odd ratio, `DIV`=3: `clk_out` pattern 0,0,1 repeating; `rise_tick` at phase 2; `fall_tick` at phase 0.
- Minimum ratio, `DIV`=2: `clk_out` toggles every cycle; `rise_tick` and `fall_tick` alternate every cycle, never both 1.
- Reset mid-run, `DIV`=4: pulse `rst_n` low at phase 3. Required: outputs return to reset values; after release, the first `rise_tick` occurs at the 2nd enabled edge.
